// File: rtl/shift_add_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : shift_add_mult_pkg                                            |
// | Description: Shared encodings for the shift-and-add multiplier. Holds the  |
// |              FSM state encoding and the datapath operation codes that the  |
// |              controller issues and the datapath decodes.                   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package shift_add_mult_pkg;

  typedef logic [2:0] state_t;
  typedef logic [2:0] dp_op_t;

  // Controller states (3-bit encoding)
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_ADD   = 3'd2;
  localparam state_t S_SHIFT = 3'd3;
  localparam state_t S_ACCUM = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Datapath operations: one per cycle, selects which registers load and
  // what the A-register ALU feeds them.
  localparam dp_op_t OP_HOLD    = 3'd0;  // no register changes
  localparam dp_op_t OP_CAPTURE = 3'd1;  // latch M, Q, D from the inputs
  localparam dp_op_t OP_CLEAR   = 3'd2;  // A <= 0
  localparam dp_op_t OP_ADD_M   = 3'd3;  // A <= A + {0,M}
  localparam dp_op_t OP_SHIFT   = 3'd4;  // {A,Q} <= {0,A,Q} >> 1
  localparam dp_op_t OP_ACCUM   = 3'd5;  // product <= {A,Q} + D

endpackage : shift_add_mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : shift_add_mult_ctrl                                           |
// | Description: Control FSM for the shift-and-add multiplier. Sequences one   |
// |              add/shift pair per multiplier bit, owns the iteration count   |
// |              and the registered busy/done handshake outputs.               |
// | Revision   : 1.0 - initial release                                         |
// |                                                                            |
// | Ports:                                                                     |
// |   clk      in   1   clock, rising edge                                     |
// |   resetn   in   1   synchronous active-low reset                           |
// |   i_go     in   1   start request, honoured only in S_IDLE                 |
// |   i_q0     in   1   current LSB of the Q register from the datapath        |
// |   o_op     out  3   datapath operation for this cycle                      |
// |   o_busy   out  1   high in every state except S_IDLE                      |
// |   o_done   out  1   one-cycle pulse while in S_DONE                        |
// +----------------------------------------------------------------------------+
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_go,
  input  logic         i_q0,
  output logic [2:0]   o_op,
  output logic         o_busy,
  output logic         o_done
);

  localparam int                CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]     c_last = CW'(WIDTH - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  dp_op_t          w_op;

  // busy/done are registered alongside the state so they track the state
  // that is entered, not the one being left.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            r_state <= S_ACCUM;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_ACCUM: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The capture op is issued in the same cycle go is seen in S_IDLE so the
  // operands are latched on that very edge; the inputs are free afterwards.
  always_comb begin
    w_op = OP_HOLD;
    case (r_state)
      S_IDLE:  if (i_go) w_op = OP_CAPTURE;
      S_LOAD:  w_op = OP_CLEAR;
      S_ADD:   if (i_q0) w_op = OP_ADD_M;
      S_SHIFT: w_op = OP_SHIFT;
      S_ACCUM: w_op = OP_ACCUM;
      default: w_op = OP_HOLD;
    endcase
  end

  assign o_op   = w_op;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule : shift_add_mult_ctrl
`default_nettype wire

// File: rtl/shift_add_mult_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : shift_add_mult_dp                                             |
// | Description: Datapath for the shift-and-add multiplier. Holds the M, Q,    |
// |              A (with carry bit), addend and product registers, the         |
// |              WIDTH+1 adder and the {A,Q} right shifter.                    |
// | Revision   : 1.0 - initial release                                         |
// |                                                                            |
// | Ports:                                                                     |
// |   clk             in   1        clock, rising edge                         |
// |   resetn          in   1        synchronous active-low reset               |
// |   i_op            in   3        operation from the controller              |
// |   i_multiplicand  in   WIDTH    M operand                                  |
// |   i_multiplier    in   WIDTH    Q operand                                  |
// |   i_addend        in   WIDTH    D operand                                  |
// |   o_q0            out  1        Q[0], steers the conditional add           |
// |   o_product       out  2*WIDTH  result register                            |
// +----------------------------------------------------------------------------+
module shift_add_mult_dp
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [2:0]           i_op,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  input  logic [WIDTH-1:0]     i_addend,
  output logic                 o_q0,
  output logic [2*WIDTH-1:0]   o_product
);

  logic [WIDTH-1:0]    r_m;
  logic [WIDTH-1:0]    r_q;
  logic [WIDTH:0]      r_a;
  logic [WIDTH-1:0]    r_d;
  logic [2*WIDTH-1:0]  r_product;

  // A is WIDTH+1 bits so the carry out of A+M is kept; the following shift
  // moves that carry into A[WIDTH-1] and leaves A[WIDTH] at zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m       <= '0;
      r_q       <= '0;
      r_a       <= '0;
      r_d       <= '0;
      r_product <= '0;
    end else begin
      case (i_op)
        OP_CAPTURE: begin
          r_m <= i_multiplicand;
          r_q <= i_multiplier;
          r_d <= i_addend;
        end
        OP_CLEAR: begin
          r_a <= '0;
        end
        OP_ADD_M: begin
          r_a <= r_a + {1'b0, r_m};
        end
        OP_SHIFT: begin
          r_a <= {1'b0, r_a[WIDTH:1]};
          r_q <= {r_a[0], r_q[WIDTH-1:1]};
        end
        OP_ACCUM: begin
          // Max M*Q+D is 2^2W - 2^W, so the 2W-bit sum cannot overflow.
          r_product <= {r_a[WIDTH-1:0], r_q} + {{WIDTH{1'b0}}, r_d};
        end
        default: begin
        end
      endcase
    end
  end

  assign o_q0      = r_q[0];
  assign o_product = r_product;

endmodule : shift_add_mult_dp
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : shift_add_multiplier                                          |
// | Description: Sequential shift-and-add multiply-accumulate,                 |
// |              product = multiplicand * multiplier + addend. Inverse         |
// |              companion of the restoring divider: feeding it {divisor,      |
// |              quotient, remainder} rebuilds the dividend. Fixed latency:    |
// |              done pulses 2*WIDTH+3 cycles after go is accepted.            |
// | Revision   : 1.0 - initial release                                         |
// |                                                                            |
// | Ports:                                                                     |
// |   clk           in   1        clock, rising edge                          |
// |   resetn        in   1        synchronous active-low reset                |
// |   go            in   1        start request, sampled only when idle       |
// |   multiplicand  in   WIDTH    M operand                                   |
// |   multiplier    in   WIDTH    Q operand                                   |
// |   addend        in   WIDTH    added to the full product                   |
// |   busy          out  1        operation in progress                       |
// |   done          out  1        one-cycle completion pulse                  |
// |   product       out  2*WIDTH  result, held until the next completion      |
// +----------------------------------------------------------------------------+
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 go,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     addend,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [2:0] w_op;
  logic       w_q0;

  shift_add_mult_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .resetn (resetn),
    .i_go   (go),
    .i_q0   (w_q0),
    .o_op   (w_op),
    .o_busy (busy),
    .o_done (done)
  );

  shift_add_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk            (clk),
    .resetn         (resetn),
    .i_op           (w_op),
    .i_multiplicand (multiplicand),
    .i_multiplier   (multiplier),
    .i_addend       (addend),
    .o_q0           (w_q0),
    .o_product      (product)
  );

endmodule : shift_add_multiplier
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_shift_add_multiplier                                       |
// | Description: Self-checking bench for shift_add_multiplier (WIDTH=4).       |
// |              Expected products are queued when go is accepted and popped   |
// |              by a monitor whenever done is seen.                           |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_shift_add_multiplier;
  import shift_add_mult_pkg::*;

  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic               go;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   addend;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int errors = 0;
  int checks = 0;
  int sb[$];
  logic prev_done = 1'b0;

  typedef struct {
    int m;
    int q;
    int d;
    int exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .WIDTH (WIDTH)
  ) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .go           (go),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  function automatic int model(input int m, input int q, input int d);
    return (m * q + d) & 255;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: handshake invariants every cycle, product vs. scoreboard on done.
  always @(negedge clk) begin
    if (resetn !== 1'b1) begin
      prev_done = 1'b0;
    end else begin
      check("busy_vs_state", int'(busy), int'(u_dut.u_ctrl.r_state != S_IDLE));
      check("done_one_cycle", int'(prev_done & done), 0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (product %0d)", product);
        end else begin
          check("product", int'(product), sb.pop_front());
        end
      end
      prev_done = done;
    end
  end

  // Call at #1 after an edge, i.e. inside cycle start_cyc; returns the cycle
  // in which done was seen, or -1 if it never came.
  task automatic wait_done(input int start_cyc, output int cyc);
    cyc = -1;
    for (int c = start_cyc; c <= start_cyc + 30; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input int m, input int q, input int d, input int exp, input string name);
    int lat;
    @(posedge clk);
    #1;
    go           = 1'b1;
    multiplicand = 4'(m);
    multiplier   = 4'(q);
    addend       = 4'(d);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    go           = 1'b0;
    multiplicand = 4'($urandom);
    multiplier   = 4'($urandom);
    addend       = 4'($urandom);
    wait_done(1, lat);
    check({name, "_latency"}, lat, 11);
    if (lat < 0) sb.delete();
    @(negedge clk);
    check({name, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int c2;

    vecs[0] = '{13, 11,  5, 148};
    vecs[1] = '{15, 15, 15, 240};
    vecs[2] = '{ 0,  9,  0,   0};
    vecs[3] = '{ 6,  0,  3,   3};
    vecs[4] = '{ 7,  7,  0,  49};
    vecs[5] = '{ 1,  1,  0,   1};
    vecs[6] = '{15,  1,  0,  15};
    vecs[7] = '{ 2,  8,  1,  17};

    // Reset and idle
    resetn       = 1'b0;
    go           = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_product", int'(product), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      multiplicand = 4'($urandom);
      multiplier   = 4'($urandom);
      addend       = 4'($urandom);
    end
    @(negedge clk);
    check("idle_product", int'(product), 0);
    check("idle_busy", int'(busy), 0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].q, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // go and new operands during busy must be ignored: 3*5+2 = 17
    @(posedge clk);
    #1;
    go = 1'b1; multiplicand = 4'd3; multiplier = 4'd5; addend = 4'd2;
    sb.push_back(17);
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    go = 1'b1; multiplicand = 4'd15; multiplier = 4'd15; addend = 4'd15;
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_done(4, c1);
    check("ignore_latency", c1, 11);
    @(negedge clk);
    check("ignore_busy_after", int'(busy), 0);
    check("ignore_product_held", int'(product), 17);

    // go held high: 2*3+1 = 7 then 5*4+3 = 23, restart in cycle 13
    @(posedge clk);
    #1;
    go = 1'b1; multiplicand = 4'd2; multiplier = 4'd3; addend = 4'd1;
    sb.push_back(7);
    sb.push_back(23);
    @(posedge clk);
    #1;
    multiplicand = 4'd5; multiplier = 4'd4; addend = 4'd3;
    wait_done(1, c1);
    check("b2b_first_done", c1, 11);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_gap_idle", int'(busy), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_restart_busy", int'(busy), 1);
    check("b2b_restart_state", int'(u_dut.u_ctrl.r_state), int'(S_LOAD));
    @(posedge clk);
    #1;
    wait_done(14, c2);
    go = 1'b0;
    check("b2b_second_done", c2, 23);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b2b_no_third", int'(busy), 0);
    check("b2b_product", int'(product), 23);

    // Reset in cycle 5 aborts the operation
    @(posedge clk);
    #1;
    go = 1'b1; multiplicand = 4'd9; multiplier = 4'd9; addend = 4'd9;
    sb.push_back(90);
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_product", int'(product), 0);
    check("abort_done", int'(done), 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("abort_stays_idle", int'(busy), 0);
    run_op(7, 7, 0, 49, "after_reset");

    // Exhaustive operand sweep against the arithmetic model
    for (int m = 0; m < 16; m++) begin
      for (int q = 0; q < 16; q++) begin
        for (int d = 0; d < 16; d++) begin
          run_op(m, q, d, model(m, q, d), "sweep");
        end
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_add_multiplier
`default_nettype wire
